// File: rtl/exp5_unidade_controle.sv
`timescale 1ns/1ps
// exp5_unidade_controle
// Moore control unit for the exp4_fluxo_dados datapath. It runs one round per
// play: wait for a play, load the switch register, compare against memory,
// advance the address counter, and finishes on a full 16-play win, a mismatch
// or (optionally) a play timeout.
//
// Optional feature macro: EXP5_UC_TIMEOUT_EN enables the play-window timeout
// counter, the fim_timeout state and the TIMEOUT_CYCLES parameter.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   iniciar              start request (level)
//   jogada               one-cycle play pulse
//   chavesIgualMemoria   datapath comparator result
//   fimC                 datapath counter at terminal value
//   zeraC/contaC         clear / increment address counter
//   zeraR/registraR      clear / load switch register
//   pronto/acertou/errou game finished / all plays matched / a play mismatched
//   timeout              play window expired (0 when the feature is absent)
//   db_estado            current state code for the debug display
module exp5_unidade_controle
`ifdef EXP5_UC_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // State codes double as the debug display value.
    typedef enum logic [3:0] {
        ST_INICIAL     = 4'b0000,
        ST_PREPARACAO  = 4'b0001,
        ST_ESPERA      = 4'b0010,
        ST_REGISTRA    = 4'b0100,
        ST_COMPARACAO  = 4'b0101,
        ST_PROXIMO     = 4'b0110,
        ST_FIM_ACERTOU = 4'b1010,
        ST_FIM_ERROU   = 4'b1110
`ifdef EXP5_UC_TIMEOUT_EN
        , ST_FIM_TIMEOUT = 4'b1101
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

`ifdef EXP5_UC_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_expired;

    // Play-window counter: runs only while waiting for a play.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ESPERA) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_expired = (cnt_q == CNT_LAST);
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown codes fall back to inicial.
    always_comb begin
        state_d = ST_INICIAL;
        case (state_q)
            ST_INICIAL:    state_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
            ST_PREPARACAO: state_d = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada) begin
                    state_d = ST_REGISTRA;
`ifdef EXP5_UC_TIMEOUT_EN
                end else if (cnt_expired) begin
                    state_d = ST_FIM_TIMEOUT;
`endif
                end else begin
                    state_d = ST_ESPERA;
                end
            end
            ST_REGISTRA:   state_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    state_d = ST_FIM_ERROU;
                end else if (fimC) begin
                    state_d = ST_FIM_ACERTOU;
                end else begin
                    state_d = ST_PROXIMO;
                end
            end
            ST_PROXIMO:     state_d = ST_ESPERA;
            ST_FIM_ACERTOU: state_d = iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
            ST_FIM_ERROU:   state_d = iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
`ifdef EXP5_UC_TIMEOUT_EN
            ST_FIM_TIMEOUT: state_d = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
`endif
            default:        state_d = ST_INICIAL;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = state_q;
        case (state_q)
            ST_PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ST_REGISTRA: registraR = 1'b1;
            ST_PROXIMO:  contaC    = 1'b1;
            ST_FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            ST_FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef EXP5_UC_TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exp5_unidade_controle.sv
`timescale 1ns/1ps
// Bench for exp5_unidade_controle: table-driven vectors for the mismatch
// round, hand-written sequences for the win, async reset and timeout cases.
module tb_exp5_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, jogada, igual, fimc;
    logic       zerac, contac, zerar, registrar, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int n_conta = 0;
    int n_reg   = 0;

    typedef struct {
        logic       ini;
        logic       jog;
        logic       ig;
        logic       fc;
        logic [3:0] exp_db;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];

`ifdef EXP5_UC_TIMEOUT_EN
    exp5_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
`else
    exp5_unidade_controle dut (
`endif
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .chavesIgualMemoria(igual), .fimC(fimc),
        .zeraC(zerac), .contaC(contac), .zeraR(zerar), .registraR(registrar),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle; each state lasts at least one cycle.
    always @(negedge clock) begin
        if (contac)    n_conta++;
        if (registrar) n_reg++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t required end earlier", $time);
        $fatal(1);
    end

    // Expected {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout,db} per state code.
    function automatic logic [11:0] model(input logic [3:0] s);
        logic [7:0] o;
        case (s)
            4'b0001: o = 8'b1010_0000;
            4'b0100: o = 8'b0001_0000;
            4'b0110: o = 8'b0100_0000;
            4'b1010: o = 8'b0000_1100;
            4'b1110: o = 8'b0000_1010;
            4'b1101: o = 8'b0000_1001;
            default: o = 8'b0000_0000;
        endcase
        return {o, s};
    endfunction

    task automatic check(input string name);
        logic [3:0]  e;
        logic [11:0] act, exp;
        e   = sb.pop_front();
        exp = model(e);
        act = {zerac, contac, zerar, registrar, pronto, acertou, errou, timeout, db_estado};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, expect state code after the next edge.
    task automatic step(input logic ini, input logic jog, input logic ig,
                        input logic fc, input logic [3:0] exp_db, input string name);
        iniciar = ini; jogada = jog; igual = ig; fimc = fc;
        sb.push_back(exp_db);
        @(posedge clock);
        #1;
        check(name);
    endtask

    task automatic start_game();
        step(1, 0, 0, 0, 4'b0001, "iniciar_to_prep");
        step(0, 0, 0, 0, 4'b0010, "prep_to_espera");
    endtask

    initial begin
        reset = 1'b0; iniciar = 0; jogada = 0; igual = 0; fimc = 0;
        repeat (2) @(posedge clock);
        #1;
        sb.push_back(4'b0000);
        check("reset_state");
        @(negedge clock);
        reset = 1'b1;
        #1;
        step(0, 1, 1, 1, 4'b0000, "idle_ignores_jogada");

        // Win: 16 plays, fimC only during the 16th comparison.
        n_conta = 0; n_reg = 0;
        start_game();
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 0, 4'b0100, "play_registra");
            step(1, 0, 0, 0, 4'b0101, "play_comparacao");
            if (k < 16) begin
                step(0, 0, 1, 0, 4'b0110, "play_proximo");
                step(0, 0, 1, 0, 4'b0010, "play_espera");
            end else begin
                step(0, 0, 1, 1, 4'b1010, "win_fim_acertou");
            end
        end
        step(0, 1, 0, 0, 4'b1010, "win_hold");
        #2;
        check_int("win_contaC_pulses", n_conta, 15);
        check_int("win_registraR_pulses", n_reg, 16);

        // Mismatch on the third play, driven from the vector table.
        vecs.push_back('{1, 0, 0, 0, 4'b0001, "lose_prep"});
        vecs.push_back('{1, 0, 0, 0, 4'b0010, "lose_espera"});
        vecs.push_back('{1, 0, 0, 0, 4'b0010, "espera_ignores_iniciar"});
        for (int k = 0; k < 2; k++) begin
            vecs.push_back('{0, 1, 0, 0, 4'b0100, "lose_registra"});
            vecs.push_back('{0, 0, 0, 0, 4'b0101, "lose_comparacao"});
            vecs.push_back('{0, 0, 1, 0, 4'b0110, "lose_proximo"});
            vecs.push_back('{0, 0, 1, 1, 4'b0010, "lose_espera2"});
        end
        vecs.push_back('{0, 1, 0, 0, 4'b0100, "lose_registra3"});
        vecs.push_back('{0, 0, 1, 1, 4'b0101, "lose_comparacao3"});
        vecs.push_back('{0, 0, 0, 1, 4'b1110, "lose_fim_errou"});
        vecs.push_back('{0, 1, 1, 1, 4'b1110, "errou_hold"});
        vecs.push_back('{1, 0, 0, 0, 4'b0001, "errou_restart"});
        vecs.push_back('{0, 0, 0, 0, 4'b0010, "restart_espera"});
        n_conta = 0;
        foreach (vecs[i]) begin
            if (vecs[i].name == "errou_restart") begin
                #2;
                check_int("lose_contaC_pulses", n_conta, 2);
            end
            step(vecs[i].ini, vecs[i].jog, vecs[i].ig, vecs[i].fc, vecs[i].exp_db, vecs[i].name);
        end

        // Asynchronous reset while in comparacao.
        step(0, 1, 0, 0, 4'b0100, "rst_registra");
        step(0, 0, 1, 0, 4'b0101, "rst_comparacao");
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(4'b0000);
        check("async_reset_mid_cycle");
        @(negedge clock);
        reset = 1'b1;
        #1;
        step(0, 1, 1, 0, 4'b0000, "post_reset_jogada");
        step(0, 0, 0, 0, 4'b0000, "post_reset_idle");

`ifdef EXP5_UC_TIMEOUT_EN
        // Timeout after 8 cycles in espera_jogada.
        start_game();
        for (int k = 1; k <= 7; k++) step(0, 0, 0, 0, 4'b0010, "to_wait");
        step(0, 0, 0, 0, 4'b1101, "to_fim_timeout");
        step(0, 0, 0, 0, 4'b1101, "to_hold");
        step(1, 0, 0, 0, 4'b0001, "to_restart");
        step(0, 0, 0, 0, 4'b0010, "to_espera");
        for (int k = 1; k <= 7; k++) step(0, 0, 0, 0, 4'b0010, "to_wait2");
        step(0, 1, 0, 0, 4'b0100, "to_jogada_priority");
        step(0, 0, 1, 0, 4'b0101, "to_comparacao");
`else
        // Without the timeout feature espera_jogada waits forever.
        start_game();
        for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 4'b0010, "no_timeout_wait");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
